// File: rtl/mem_copy_master.sv
// Word-copy initiator on the core data interface. It runs one read and then one write per word,
// keeps only one transaction outstanding, and inserts a one-cycle gap after each accepted request.
// Bus packing: bus_m2s_o = {data_req, data_addr[31:0], data_we, data_be[3:0], data_wdata[31:0]},
//              bus_s2m_i = {data_gnt, data_rvalid, data_rdata[31:0]}.
module mem_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_words_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic [69:0]      bus_m2s_o,
  input  logic [33:0]      bus_s2m_i,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_GAP  = 3'd3,
    WR_REQ  = 3'd4,
    WR_GAP  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr, rdata_q;
  logic [LEN_W-1:0] len_q, words_done_q;

  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic        unused_addr_lsbs;

  assign data_gnt         = bus_s2m_i[33];
  assign data_rvalid      = bus_s2m_i[32];
  assign data_rdata       = bus_s2m_i[31:0];
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      len_q        <= '0;
      rdata_q      <= '0;
      words_done_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            words_done_q <= '0;
            if (len_words_i != '0) begin
              src_ptr <= {src_addr_i[31:2], 2'b00};
              dst_ptr <= {dst_addr_i[31:2], 2'b00};
              len_q   <= len_words_i;
            end
          end
        end
        RD_REQ:  if (data_gnt && data_rvalid) rdata_q <= data_rdata;
        RD_WAIT: if (data_rvalid) rdata_q <= data_rdata;
        WR_REQ: begin
          if (data_gnt) begin
            src_ptr      <= src_ptr + 32'd4;
            dst_ptr      <= dst_ptr + 32'd4;
            words_done_q <= words_done_q + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Gap states unconditionally move on, so a duplicate grant/rvalid from a
  // registered-grant responder lands where nothing listens.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = (len_words_i != '0) ? RD_REQ : DONE;
      end
      RD_REQ: begin
        if (data_gnt) state_nxt = data_rvalid ? RD_GAP : RD_WAIT;
      end
      RD_WAIT: if (data_rvalid) state_nxt = RD_GAP;
      RD_GAP:  state_nxt = WR_REQ;
      WR_REQ:  if (data_gnt) state_nxt = WR_GAP;
      WR_GAP:  state_nxt = (words_done_q == len_q) ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs decode registered state and pointers only.
  always_comb begin
    data_req  = 1'b0;
    data_we   = 1'b0;
    data_be   = 4'b0000;
    data_addr = src_ptr;
    unique case (state)
      RD_REQ: begin
        data_req = 1'b1;
        data_be  = 4'b1111;
      end
      WR_REQ: begin
        data_req  = 1'b1;
        data_we   = 1'b1;
        data_be   = 4'b1111;
        data_addr = dst_ptr;
      end
      default: ;
    endcase
  end

  assign bus_m2s_o    = {data_req, data_addr, data_we, data_be, rdata_q};
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign words_done_o = words_done_q;
  assign dbg_state    = state;

endmodule
